// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU block.
// Provides the 3-bit ALU opcode encodings and the arbiter FSM state type.
// No ports (package).
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU used as the shared datapath of alu_arbiter.
// Ports:
//   i_opa, i_opb  operands (DATA_WIDTH)
//   i_op          opcode (see alu_pkg)
//   o_result      result (DATA_WIDTH)
//   o_zero        result == 0
//   o_carry       carry out of ADD; 0 for every other opcode
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_opa,
  input  logic [DATA_WIDTH-1:0] i_opb,
  input  logic [2:0]            i_op,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_zero,
  output logic                  o_carry
);

  logic [DATA_WIDTH:0] w_sum;
  logic                w_shift_oor;

  assign w_sum = {1'b0, i_opa} + {1'b0, i_opb};
  // The whole of operand B is the shift amount; anything >= width clears the result.
  assign w_shift_oor = ({1'b0, i_opb} >= (DATA_WIDTH+1)'(DATA_WIDTH));

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = w_sum[DATA_WIDTH-1:0];
        o_carry  = w_sum[DATA_WIDTH];
      end
      OP_SUB: o_result = i_opa - i_opb;
      OP_AND: o_result = i_opa & i_opb;
      OP_OR:  o_result = i_opa | i_opb;
      OP_XOR: o_result = i_opa ^ i_opb;
      OP_SHL: o_result = w_shift_oor ? '0 : (i_opa << i_opb);
      OP_SHR: o_result = w_shift_oor ? '0 : (i_opa >> i_opb);
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters.
// Ports:
//   clk, rst                    clock / async active-high reset
//   req_valid/req_ready         per-requester handshake, req_ready one-hot
//   req_opa/req_opb/req_opcode  packed per-requester operands and opcode
//   rsp_valid/rsp_ready         response handshake
//   rsp_id/result/zero/carry    response payload
//   busy                        FSM not idle
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REQ    = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_opa,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_opb,
  input  logic [NUM_REQ*3-1:0]          req_opcode,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic                          rsp_zero,
  output logic                          rsp_carry,
  output logic                          busy
);

  // Returns {found, index} of the first valid requester at or after ptr.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] pick;
    int            idx;
    pick = '0;
    // Walk from farthest to nearest so the nearest valid index wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (v[idx]) pick = {1'b1, idx[ID_W-1:0]};
    end
    return pick;
  endfunction

  arb_state_t            r_state;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [DATA_WIDTH-1:0] r_opa_p0;
  logic [DATA_WIDTH-1:0] r_opb_p0;
  logic [2:0]            r_op_p0;
  logic [ID_W-1:0]       r_id_p0;

  logic [ID_W:0]         w_pick;
  logic [ID_W-1:0]       w_gnt;
  logic [ID_W-1:0]       w_next_ptr;
  logic                  w_window;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_alu_result;
  logic                  w_alu_zero;
  logic                  w_alu_carry;

  assign w_pick     = rr_pick(req_valid, r_rr_ptr);
  assign w_gnt      = w_pick[ID_W-1:0];
  assign w_next_ptr = (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
  assign w_window   = (r_state == IDLE) || ((r_state == RESP) && rsp_ready);
  assign w_accept   = w_window && w_pick[ID_W];
  assign busy       = (r_state != IDLE);

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_gnt] = 1'b1;
  end

  // Stage p0 -> ALU: operand registers drive the shared datapath during EXEC.
  alu_arbiter_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .i_opa   (r_opa_p0),
    .i_opb   (r_opb_p0),
    .i_op    (r_op_p0),
    .o_result(w_alu_result),
    .o_zero  (w_alu_zero),
    .o_carry (w_alu_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_opa_p0   <= '0;
      r_opb_p0   <= '0;
      r_op_p0    <= '0;
      r_id_p0    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_opa_p0 <= req_opa[w_gnt*DATA_WIDTH +: DATA_WIDTH];
        r_opb_p0 <= req_opb[w_gnt*DATA_WIDTH +: DATA_WIDTH];
        r_op_p0  <= req_opcode[w_gnt*3 +: 3];
        r_id_p0  <= w_gnt;
        r_rr_ptr <= w_next_ptr;
      end
      case (r_state)
        IDLE: if (w_accept) r_state <= EXEC;
        // ALU output -> response registers; payload then holds until consumed.
        EXEC: begin
          r_state    <= RESP;
          rsp_valid  <= 1'b1;
          rsp_id     <= r_id_p0;
          rsp_result <= w_alu_result;
          rsp_zero   <= w_alu_zero;
          rsp_carry  <= w_alu_carry;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= w_accept ? EXEC : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter (DATA_WIDTH=8, NUM_REQ=4).
module tb_alu_arbiter;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, NOP = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_opa = '0;
  logic [31:0] req_opb = '0;
  logic [11:0] req_opcode = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_result;
  logic        rsp_zero;
  logic        rsp_carry;
  logic        busy;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] res;
    logic       z;
    logic       c;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_opcode(req_opcode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per completed response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_result", 32'(rsp_result), 32'(e.res));
          chk("rsp_zero", 32'(rsp_zero), 32'(e.z));
          chk("rsp_carry", 32'(rsp_carry), 32'(e.c));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    req_valid[i]        = v;
    req_opcode[i*3 +: 3] = op;
    req_opa[i*8 +: 8]    = a;
    req_opb[i*8 +: 8]    = b;
  endtask

  task automatic push(input int i, input logic [7:0] r, input logic z, input logic c);
    exp_t e;
    e.id = 2'(i); e.res = r; e.z = z; e.c = c;
    q.push_back(e);
  endtask

  // Single isolated op from requester i starting in IDLE; checks grant and 2-clk latency.
  task automatic issue(input int i, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] r, input logic z,
                       input logic c);
    set_req(i, 1'b1, op, a, b);
    push(i, r, z, c);
    @(negedge clk);
    chk("grant", 32'(req_ready), 32'(4'b1 << i));
    tick();
    req_valid[i] = 1'b0;
    @(negedge clk);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_busy", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    chk("resp_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [1:0] gseq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] rseq [4] = '{8'h01, 8'h12, 8'h23, 8'h34};

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: ADD with carry out
    issue(0, ADD, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1);
    chk("idle_busy", 32'(busy), 32'd0);

    // 2: all requesters valid, back-to-back round robin from ptr 0
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, ADD, 8'(i*16 + 1), 8'(i));
    for (int k = 0; k < 5; k++) begin
      push(int'(gseq[k]), rseq[gseq[k]], 1'b0, 1'b0);
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(4'b1 << gseq[k]));
      tick();
      if (k == 4) req_valid = '0;
      @(negedge clk);
      chk("rr_exec_noready", 32'(req_ready), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("rr_last_valid", 32'(rsp_valid), 32'd1);
    tick();

    // 3: backpressure holds the response and blocks accepts (ptr now 1)
    rsp_ready = 1'b0;
    set_req(2, 1'b1, ADD, 8'h7F, 8'h01);
    push(2, 8'h80, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_grant2", 32'(req_ready), 32'b0100);
    tick();
    req_valid[2] = 1'b0;
    set_req(0, 1'b1, ADD, 8'h02, 8'h03);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd2);
      chk("bp_result", 32'(rsp_result), 32'h80);
      chk("bp_noaccept", 32'(req_ready), 32'd0);
      tick();
    end
    push(0, 8'h05, 1'b0, 1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_on_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid[0] = 1'b0;
    tick();
    @(negedge clk);
    chk("bp_second_valid", 32'(rsp_valid), 32'd1);
    tick();

    // 4: zero results (ptr now 1)
    issue(1, SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0);
    issue(2, NOP, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    // 5: shifts incl. out-of-range amount
    issue(3, SHL, 8'h81, 8'd1, 8'h02, 1'b0, 1'b0);
    issue(3, SHR, 8'h81, 8'd9, 8'h00, 1'b1, 1'b0);
    issue(3, SHR, 8'h81, 8'd1, 8'h40, 1'b0, 1'b0);
    issue(0, AND_, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    issue(1, OR_, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0);
    issue(2, XOR_, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0);
    issue(3, ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    issue(0, SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0);

    // 6: reset during EXEC (ptr now 1; grant 1 moves it to 2)
    set_req(1, 1'b1, ADD, 8'h11, 8'h22);
    @(negedge clk);
    chk("r6_grant1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    #1 rst = 1'b1;
    #1;
    chk("r6_async_valid", 32'(rsp_valid), 32'd0);
    chk("r6_async_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("r6_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    @(negedge clk);
    chk("r6_lowest_grant", 32'(req_ready), 32'b0010);
    req_valid = '0;
    tick();
    @(negedge clk);
    chk("r6_idle", 32'(busy), 32'd0);

    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
